// File: rtl/spi_responder.sv
// Purpose : SPI mode-0 responder exposing a 16x8 register file (WRITE 0x02 / READ 0x03, auto-increment) plus a local parallel port.
// Latency : 3 CLK from any SPI pin edge to its action (2-flop synchronizer + edge register); WSTB 3 CLK after the 8th SCK rise of a data byte.
// Backpressure: none; the SPI master paces everything, and an SPI commit beats a same-address local write in the same CLK.
//
// Ports:
//   CLK, RST            system clock, asynchronous active-high reset
//   SCK, MOSI, nSS      SPI inputs from the master (oversampled on CLK)
//   MISO                SPI data to the master, forced to 0 while deselected
//   LADDR/LWDATA/LWE    local write port; LRDATA is a combinational read of reg[LADDR]
//   WSTB/WADDR          one-cycle strobe and address of each committed SPI write
// Build option: define SPI_RESPONDER_ID_EN to add the 0x9F ID command (returns ID_BYTE).
module spi_responder
`ifdef SPI_RESPONDER_ID_EN
#(
    parameter logic [7:0] ID_BYTE = 8'hA5
)
`endif
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       SCK,
    input  logic       MOSI,
    input  logic       nSS,
    output logic       MISO,
    input  logic [3:0] LADDR,
    input  logic [7:0] LWDATA,
    input  logic       LWE,
    output logic [7:0] LRDATA,
    output logic       WSTB,
    output logic [3:0] WADDR
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WADDR,
        ST_WDATA,
        ST_RADDR,
        ST_RDATA,
        ST_IGNORE
`ifdef SPI_RESPONDER_ID_EN
        , ST_ID
`endif
    } state_t;

    state_t      state;
    logic        sck_s1, sck_s2, sck_d;
    logic        mosi_s1, mosi_s2;
    logic        nss_s1, nss_s2, nss_d;
    logic [2:0]  bitcnt;
    logic [7:0]  rx;
    logic [7:0]  tx;
    logic [7:0]  nxt;
    logic [3:0]  ptr;
    logic [7:0]  regs [16];

    logic        sel;
    logic        sel_rise, sel_fall;
    logic        sck_rise, sck_fall;
    logic        active;
    logic        byte_done;
    logic        spi_we;
    logic [7:0]  rx_nxt;

    assign sel       = ~nss_s2;
    assign sel_rise  = ~nss_s2 & nss_d;
    assign sel_fall  = nss_s2 & ~nss_d;
    assign sck_rise  = sck_s2 & ~sck_d;
    assign sck_fall  = ~sck_s2 & sck_d;
    // Select edges take priority over SCK edges seen in the same CLK.
    assign active    = sel & ~sel_rise & (state != ST_IDLE);
    assign rx_nxt    = {rx[6:0], mosi_s2};
    assign byte_done = active & sck_rise & (bitcnt == 3'd7);
    assign spi_we    = byte_done & (state == ST_WDATA);

    assign LRDATA = regs[LADDR];

    // Register file: the SPI commit is applied last so it overrides a local
    // write to the same address in the same CLK.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
        end else begin
            if (LWE)    regs[LADDR] <= LWDATA;
            if (spi_we) regs[ptr]   <= rx_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_d   <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            nss_s1  <= 1'b1;
            nss_s2  <= 1'b1;
            nss_d   <= 1'b1;
            state   <= ST_IDLE;
            bitcnt  <= 3'd0;
            rx      <= 8'h00;
            tx      <= 8'h00;
            nxt     <= 8'h00;
            ptr     <= 4'd0;
            MISO    <= 1'b0;
            WSTB    <= 1'b0;
            WADDR   <= 4'd0;
        end else begin
            sck_s1  <= SCK;
            sck_s2  <= sck_s1;
            sck_d   <= sck_s2;
            mosi_s1 <= MOSI;
            mosi_s2 <= mosi_s1;
            nss_s1  <= nSS;
            nss_s2  <= nss_s1;
            nss_d   <= nss_s2;
            WSTB    <= 1'b0;

            if (sel_fall) begin
                // Deselect drops any partial byte; nothing is committed.
                state  <= ST_IDLE;
                bitcnt <= 3'd0;
                MISO   <= 1'b0;
                nxt    <= 8'h00;
                tx     <= 8'h00;
            end else if (sel_rise) begin
                state  <= ST_CMD;
                bitcnt <= 3'd0;
                MISO   <= 1'b0;
                nxt    <= 8'h00;
                tx     <= 8'h00;
            end else if (active && sck_rise) begin
                rx     <= rx_nxt;
                bitcnt <= bitcnt + 3'd1;
                if (bitcnt == 3'd7) begin
                    case (state)
                        ST_CMD: begin
                            case (rx_nxt)
                                8'h02: begin state <= ST_WADDR; nxt <= 8'h00; end
                                8'h03: begin state <= ST_RADDR; nxt <= 8'h00; end
`ifdef SPI_RESPONDER_ID_EN
                                8'h9F: begin state <= ST_ID;    nxt <= ID_BYTE; end
`endif
                                default: begin state <= ST_IGNORE; nxt <= 8'hFF; end
                            endcase
                        end
                        ST_WADDR: begin
                            ptr   <= rx_nxt[3:0];
                            nxt   <= 8'h00;
                            state <= ST_WDATA;
                        end
                        ST_WDATA: begin
                            WSTB  <= 1'b1;
                            WADDR <= ptr;
                            ptr   <= ptr + 4'd1;
                            nxt   <= 8'h00;
                        end
                        ST_RADDR: begin
                            // Snapshot the addressed byte now; later local writes
                            // are only seen on a subsequent pass.
                            nxt   <= regs[rx_nxt[3:0]];
                            ptr   <= rx_nxt[3:0] + 4'd1;
                            state <= ST_RDATA;
                        end
                        ST_RDATA: begin
                            nxt <= regs[ptr];
                            ptr <= ptr + 4'd1;
                        end
`ifdef SPI_RESPONDER_ID_EN
                        ST_ID:     nxt <= ID_BYTE;
`endif
                        ST_IGNORE: nxt <= 8'hFF;
                        default:   nxt <= 8'h00;
                    endcase
                end
            end else if (active && sck_fall) begin
                // bitcnt==0 here means a byte just completed: start shifting
                // out the freshly prepared response byte.
                if (bitcnt == 3'd0) begin
                    MISO <= nxt[7];
                    tx   <= {nxt[6:0], 1'b0};
                end else begin
                    MISO <= tx[7];
                    tx   <= {tx[6:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_responder.sv
module tb_spi_responder;

    logic       CLK = 1'b0;
    logic       RST;
    logic       SCK;
    logic       MOSI;
    logic       nSS;
    logic       MISO;
    logic [3:0] LADDR;
    logic [7:0] LWDATA;
    logic       LWE;
    logic [7:0] LRDATA;
    logic       WSTB;
    logic [3:0] WADDR;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0] exp_miso_q [$];
    logic [3:0] exp_w_q    [$];
    logic [3:0] got_w_q    [$];

`ifdef SPI_RESPONDER_ID_EN
    localparam logic [7:0] ID_RESP = 8'hA5;
`else
    localparam logic [7:0] ID_RESP = 8'hFF;
`endif

    spi_responder dut (
        .CLK    (CLK),
        .RST    (RST),
        .SCK    (SCK),
        .MOSI   (MOSI),
        .nSS    (nSS),
        .MISO   (MISO),
        .LADDR  (LADDR),
        .LWDATA (LWDATA),
        .LWE    (LWE),
        .LRDATA (LRDATA),
        .WSTB   (WSTB),
        .WADDR  (WADDR)
    );

    always #5 CLK = ~CLK;

    // Record every cycle WSTB is high; a stuck strobe shows up as extra entries.
    always @(negedge CLK) begin
        if (WSTB === 1'b1) got_w_q.push_back(WADDR);
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_wstb(input string tag);
        check({tag, "_wstb_count"}, 8'(got_w_q.size()), 8'(exp_w_q.size()));
        while (exp_w_q.size() > 0 && got_w_q.size() > 0)
            check({tag, "_waddr"}, {4'h0, got_w_q.pop_front()}, {4'h0, exp_w_q.pop_front()});
        exp_w_q.delete();
        got_w_q.delete();
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic lwrite(input logic [3:0] a, input logic [7:0] d);
        @(negedge CLK);
        LADDR = a; LWDATA = d; LWE = 1'b1;
        @(negedge CLK);
        LWE = 1'b0;
    endtask

    task automatic select();
        @(negedge CLK);
        nSS = 1'b0;
        wait_clk(5);
    endtask

    task automatic deselect();
        wait_clk(4);
        nSS = 1'b1;
        wait_clk(6);
    endtask

    // Shift n bits of b (MSB first). MISO is sampled as the master would,
    // just before each rising SCK. With coll set, a local write is placed on
    // exactly the CLK where the 8th bit's SPI commit lands.
    task automatic send_bits(input logic [7:0] b, input int n, input bit coll,
                             input logic [3:0] ca, input logic [7:0] cd,
                             output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < n; i++) begin
            MOSI = b[7-i];
            wait_clk(4);
            got  = {got[6:0], MISO};
            SCK  = 1'b1;
            if (coll && i == 7) begin
                wait_clk(2);
                LADDR = ca; LWDATA = cd; LWE = 1'b1;
                wait_clk(1);
                LWE = 1'b0;
                wait_clk(1);
            end else begin
                wait_clk(4);
            end
            SCK = 1'b0;
        end
    endtask

    task automatic xfer_c(input string tag, input logic [7:0] b, input logic [7:0] exp,
                          input bit coll, input logic [3:0] ca, input logic [7:0] cd);
        logic [7:0] got;
        exp_miso_q.push_back(exp);
        send_bits(b, 8, coll, ca, cd, got);
        check({tag, "_miso"}, got, exp_miso_q.pop_front());
    endtask

    task automatic xfer(input string tag, input logic [7:0] b, input logic [7:0] exp);
        xfer_c(tag, b, exp, 1'b0, 4'h0, 8'h00);
    endtask

    task automatic check_reg(input string tag, input logic [3:0] a, input logic [7:0] exp);
        LADDR = a;
        #1;
        check(tag, LRDATA, exp);
    endtask

    initial begin
        logic [7:0] dummy;
        RST = 1'b1; SCK = 1'b0; MOSI = 1'b0; nSS = 1'b1;
        LADDR = 4'h0; LWDATA = 8'h00; LWE = 1'b0;
        wait_clk(3);
        RST = 1'b0;
        wait_clk(2);
        check("reset_miso",  {7'h0, MISO}, 8'h00);
        check("reset_wstb",  {7'h0, WSTB}, 8'h00);
        check("reset_waddr", {4'h0, WADDR}, 8'h00);
        check_reg("reset_reg0", 4'h0, 8'h00);

        // Write burst with auto-increment
        select();
        xfer("wr_cmd", 8'h02, 8'h00);
        xfer("wr_adr", 8'h03, 8'h00);
        exp_w_q.push_back(4'h3); xfer("wr_d0", 8'h11, 8'h00);
        exp_w_q.push_back(4'h4); xfer("wr_d1", 8'h22, 8'h00);
        exp_w_q.push_back(4'h5); xfer("wr_d2", 8'h33, 8'h00);
        deselect();
        check_wstb("wr");
        check_reg("wr_reg3", 4'h3, 8'h11);
        check_reg("wr_reg4", 4'h4, 8'h22);
        check_reg("wr_reg5", 4'h5, 8'h33);

        // Read with pointer wrap 15 -> 0
        lwrite(4'hF, 8'hAB);
        lwrite(4'h0, 8'hCD);
        select();
        xfer("rd_cmd", 8'h03, 8'h00);
        xfer("rd_adr", 8'h0F, 8'h00);
        xfer("rd_d0",  8'h00, 8'hAB);
        xfer("rd_d1",  8'h00, 8'hCD);
        deselect();
        check("rd_miso_idle", {7'h0, MISO}, 8'h00);
        check_wstb("rd");

        // ID command (or unknown command when the option is off)
        select();
        xfer("id_cmd", 8'h9F, 8'h00);
        xfer("id_b0",  8'h00, ID_RESP);
        xfer("id_b1",  8'h00, ID_RESP);
        deselect();
        check("id_miso_idle", {7'h0, MISO}, 8'h00);

        // Aborted write: partial data byte must not commit
        lwrite(4'h7, 8'h5A);
        select();
        xfer("ab_cmd", 8'h02, 8'h00);
        xfer("ab_adr", 8'h07, 8'h00);
        send_bits(8'hFF, 5, 1'b0, 4'h0, 8'h00, dummy);
        deselect();
        check_wstb("ab");
        check_reg("ab_reg7", 4'h7, 8'h5A);
        select();
        xfer("ab_rcmd", 8'h03, 8'h00);
        xfer("ab_radr", 8'h07, 8'h00);
        xfer("ab_rd",   8'h00, 8'h5A);
        deselect();

        // Collision: SPI wins on same address, other address proceeds
        select();
        xfer("co_cmd", 8'h02, 8'h00);
        xfer("co_adr", 8'h02, 8'h00);
        exp_w_q.push_back(4'h2);
        xfer_c("co_d", 8'h99, 8'h00, 1'b1, 4'h2, 8'h55);
        deselect();
        check_wstb("co");
        check_reg("co_reg2", 4'h2, 8'h99);
        select();
        xfer("co2_cmd", 8'h02, 8'h00);
        xfer("co2_adr", 8'h0A, 8'h00);
        exp_w_q.push_back(4'hA);
        xfer_c("co2_d", 8'h98, 8'h00, 1'b1, 4'h8, 8'h3C);
        deselect();
        check_wstb("co2");
        check_reg("co2_reg10", 4'hA, 8'h98);
        check_reg("co2_reg8",  4'h8, 8'h3C);

        // Reset in the middle of a data byte
        select();
        xfer("rs_cmd", 8'h02, 8'h00);
        xfer("rs_adr", 8'h01, 8'h00);
        send_bits(8'hFF, 4, 1'b0, 4'h0, 8'h00, dummy);
        RST = 1'b1;
        #1;
        check("rs_miso", {7'h0, MISO}, 8'h00);
        check("rs_wstb", {7'h0, WSTB}, 8'h00);
        for (int a = 0; a < 16; a++) check_reg("rs_regs", 4'(a), 8'h00);
        wait_clk(2);
        nSS = 1'b1;
        RST = 1'b0;
        wait_clk(6);
        check_wstb("rs");
        select();
        xfer("rs2_cmd", 8'h02, 8'h00);
        xfer("rs2_adr", 8'h00, 8'h00);
        exp_w_q.push_back(4'h0);
        xfer("rs2_d",   8'h77, 8'h00);
        deselect();
        check_wstb("rs2");
        check_reg("rs2_reg0", 4'h0, 8'h77);
        check_reg("rs2_reg1", 4'h1, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
